ibex_pext_mul_seq: RTL and testbench

- Multi-cycle sequencer for the Zpn 16-bit and 8-bit multiply / multiply-accumulate subset.
- Sits in the EX stage beside the ALU. It accepts one `zpn_op_e` operation at a time, then time-shares a single 17x17 signed multiplier across the partial products of that operation.
- Accumulates the products, applies accumulate, saturate and halving rules, and returns a 32-bit result plus a `vxsat` (OV) set pulse for the CSR block.

---
 rtl/ibex_pkg_pext.sv | 65 ++++++
 rtl/ibex_pext_mul17.sv | 15 +
 rtl/ibex_pext_mul_seq.sv | 245 ++++++++++++++++++++++++
 tb/tb_ibex_pext_mul_seq.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/ibex_pkg_pext.sv
// Shared types for the Zpn packed-SIMD multiply sequencer.
//   zpn_op_e        : opcode of the 16-bit / 8-bit multiply(-accumulate) subset
//   mul_seq_state_e : sequencer FSM state
//   MulAccW/MulOpW  : accumulator and multiplier operand widths
package ibex_pkg_pext;

    localparam int unsigned MulAccW  = 35;
    localparam int unsigned MulOpW   = 17;
    localparam int unsigned MulProdW = 2 * MulOpW;
    localparam int unsigned ZpnOpW   = 7;

    typedef enum logic [ZpnOpW-1:0] {
        ZPN_SMBB16 = 7'h00,
        ZPN_SMBT16 = 7'h01,
        ZPN_SMTT16 = 7'h02,
        ZPN_KHMBB  = 7'h03,
        ZPN_KHMBT  = 7'h04,
        ZPN_KHMTT  = 7'h05,
        ZPN_KMABB  = 7'h06,
        ZPN_KMABT  = 7'h07,
        ZPN_KMATT  = 7'h08,
        ZPN_KMDA   = 7'h09,
        ZPN_KMXDA  = 7'h0A,
        ZPN_SMDS   = 7'h0B,
        ZPN_KMADA  = 7'h0C,
        ZPN_SMAQA  = 7'h0D,
        ZPN_UMAQA  = 7'h0E
    } zpn_op_e;

    typedef enum logic [1:0] {
        MUL_SEQ_IDLE = 2'd0,
        MUL_SEQ_MUL  = 2'd1,
        MUL_SEQ_DONE = 2'd2
    } mul_seq_state_e;

    // Number of partial products; 0 marks an opcode this unit does not handle.
    function automatic logic [2:0] mul_seq_num_prod(input zpn_op_e op);
        logic [2:0] n;
        n = 3'd0;
        case (op)
            ZPN_SMBB16, ZPN_SMBT16, ZPN_SMTT16,
            ZPN_KHMBB,  ZPN_KHMBT,  ZPN_KHMTT,
            ZPN_KMABB,  ZPN_KMABT,  ZPN_KMATT:  n = 3'd1;
            ZPN_KMDA,   ZPN_KMXDA,  ZPN_SMDS,
            ZPN_KMADA:                          n = 3'd2;
            ZPN_SMAQA,  ZPN_UMAQA:              n = 3'd4;
            default:                            n = 3'd0;
        endcase
        return n;
    endfunction

    // Clip a 35-bit signed value to signed 32 bits; returns {clipped, value}.
    function automatic logic [32:0] mul_seq_sat32(input logic [MulAccW-1:0] s);
        logic [32:0] r;
        if ((s[MulAccW-1:31] == '0) || (s[MulAccW-1:31] == '1)) begin
            r = {1'b0, s[31:0]};
        end else if (s[MulAccW-1]) begin
            r = {1'b1, 32'h8000_0000};
        end else begin
            r = {1'b1, 32'h7FFF_FFFF};
        end
        return r;
    endfunction

endpackage

// File: rtl/ibex_pext_mul17.sv
// Combinational 17x17 signed multiplier, isolated so a DSP or Booth
// implementation can replace it without touching the sequencer.
//   a_i, b_i : signed 17-bit operands
//   p_o      : signed 34-bit product
module ibex_pext_mul17
    import ibex_pkg_pext::*;
(
    input  logic signed [MulOpW-1:0]   a_i,
    input  logic signed [MulOpW-1:0]   b_i,
    output logic signed [MulProdW-1:0] p_o
);

    assign p_o = MulProdW'(a_i) * MulProdW'(b_i);

endmodule

// File: rtl/ibex_pext_mul_seq.sv
// Multi-cycle sequencer for the Zpn 16/8-bit multiply and multiply-accumulate
// ops. One operation at a time; a single 17x17 multiplier is time-shared over
// the partial products, which are summed into a 35-bit accumulator and then
// finalised (accumulate, saturate, halve) into a 32-bit result.
//   clk_i, rst_i        : clock, synchronous active-high reset
//   en_i, operator_i    : request valid and opcode
//   op_a_i/op_b_i/op_c_i: rs1, rs2, old rd
//   kill_i              : flush the in-flight operation
//   ready_o             : idle, can accept
//   valid_o, result_o   : one-cycle result pulse and value
//   ov_set_o            : saturation flag, qualified by valid_o
module ibex_pext_mul_seq
    import ibex_pkg_pext::*;
#(
    parameter bit ResetAll = 1'b0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic [ZpnOpW-1:0] operator_i,
    input  logic [31:0]       op_a_i,
    input  logic [31:0]       op_b_i,
    input  logic [31:0]       op_c_i,
    input  logic              kill_i,
    output logic              ready_o,
    output logic              valid_o,
    output logic [31:0]       result_o,
    output logic              ov_set_o
);

    mul_seq_state_e state_q;
    logic           ready_q;
    logic           valid_q;
    logic           ov_q;
    logic [31:0]    result_q;

    zpn_op_e                    op_q;
    logic [31:0]                a_q;
    logic [31:0]                b_q;
    logic [31:0]                c_q;
    logic signed [MulAccW-1:0]  acc_q;
    logic [1:0]                 k_q;
    logic [1:0]                 k_last_q;

    zpn_op_e                    op_in;
    logic [2:0]                 n_in;
    logic                       accept;

    logic signed [MulOpW-1:0]   mul_a;
    logic signed [MulOpW-1:0]   mul_b;
    logic                       mul_neg;
    logic signed [MulProdW-1:0] prod;
    logic signed [MulAccW-1:0]  prod_ext;
    logic signed [MulAccW-1:0]  acc_d;
    logic [MulAccW-1:0]         acc_c;
    logic [32:0]                sat_acc;
    logic [32:0]                sat_accc;
    logic [31:0]                res_d;
    logic                       ov_d;

    assign op_in  = zpn_op_e'(operator_i);
    assign n_in   = mul_seq_num_prod(op_in);
    assign accept = (state_q == MUL_SEQ_IDLE) && en_i && !kill_i;

    // Pick the multiplier operands for partial product k of the current op.
    always_comb begin
        logic [7:0] a_byte;
        logic [7:0] b_byte;
        mul_a   = '0;
        mul_b   = '0;
        mul_neg = 1'b0;
        a_byte  = a_q[{k_q, 3'b000} +: 8];
        b_byte  = b_q[{k_q, 3'b000} +: 8];
        case (op_q)
            ZPN_SMBB16, ZPN_KHMBB, ZPN_KMABB: begin
                mul_a = {a_q[15], a_q[15:0]};
                mul_b = {b_q[15], b_q[15:0]};
            end
            ZPN_SMBT16, ZPN_KHMBT, ZPN_KMABT: begin
                mul_a = {a_q[15], a_q[15:0]};
                mul_b = {b_q[31], b_q[31:16]};
            end
            ZPN_SMTT16, ZPN_KHMTT, ZPN_KMATT: begin
                mul_a = {a_q[31], a_q[31:16]};
                mul_b = {b_q[31], b_q[31:16]};
            end
            ZPN_KMDA, ZPN_SMDS, ZPN_KMADA: begin
                if (k_q == 2'd0) begin
                    mul_a = {a_q[31], a_q[31:16]};
                    mul_b = {b_q[31], b_q[31:16]};
                end else begin
                    mul_a = {a_q[15], a_q[15:0]};
                    mul_b = {b_q[15], b_q[15:0]};
                end
                mul_neg = (op_q == ZPN_SMDS) && (k_q == 2'd1);
            end
            ZPN_KMXDA: begin
                if (k_q == 2'd0) begin
                    mul_a = {a_q[31], a_q[31:16]};
                    mul_b = {b_q[15], b_q[15:0]};
                end else begin
                    mul_a = {a_q[15], a_q[15:0]};
                    mul_b = {b_q[31], b_q[31:16]};
                end
            end
            ZPN_SMAQA: begin
                mul_a = {{9{a_byte[7]}}, a_byte};
                mul_b = {{9{b_byte[7]}}, b_byte};
            end
            ZPN_UMAQA: begin
                mul_a = {9'b0, a_byte};
                mul_b = {9'b0, b_byte};
            end
            default: begin
                mul_a = '0;
                mul_b = '0;
            end
        endcase
    end

    ibex_pext_mul17 u_mul17 (
        .a_i (mul_a),
        .b_i (mul_b),
        .p_o (prod)
    );

    assign prod_ext = MulAccW'(prod);
    assign acc_d    = mul_neg ? (acc_q - prod_ext) : (acc_q + prod_ext);
    assign acc_c    = acc_d + {{(MulAccW-32){c_q[31]}}, c_q};
    assign sat_acc  = mul_seq_sat32(acc_d);
    assign sat_accc = mul_seq_sat32(acc_c);

    // Finalise using the accumulator value that includes the last product.
    always_comb begin
        res_d = '0;
        ov_d  = 1'b0;
        case (op_q)
            ZPN_SMBB16, ZPN_SMBT16, ZPN_SMTT16, ZPN_SMDS: begin
                res_d = acc_d[31:0];
            end
            ZPN_KHMBB, ZPN_KHMBT, ZPN_KHMTT: begin
                // -1.0 * -1.0 in Q15 is the only product that cannot be represented.
                if ((mul_a == 17'h18000) && (mul_b == 17'h18000)) begin
                    res_d = 32'h0000_7FFF;
                    ov_d  = 1'b1;
                end else begin
                    res_d = {{16{acc_d[30]}}, acc_d[30:15]};
                end
            end
            ZPN_KMDA, ZPN_KMXDA: begin
                res_d = sat_acc[31:0];
                ov_d  = sat_acc[32];
            end
            ZPN_KMABB, ZPN_KMABT, ZPN_KMATT, ZPN_KMADA: begin
                res_d = sat_accc[31:0];
                ov_d  = sat_accc[32];
            end
            ZPN_SMAQA, ZPN_UMAQA: begin
                res_d = c_q + acc_d[31:0];
            end
            default: begin
                res_d = '0;
                ov_d  = 1'b0;
            end
        endcase
    end

    // Sequencer FSM and handshake outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= MUL_SEQ_IDLE;
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
            ov_q     <= 1'b0;
            result_q <= '0;
        end else begin
            valid_q <= 1'b0;
            ov_q    <= 1'b0;
            case (state_q)
                MUL_SEQ_IDLE: begin
                    if (accept) begin
                        ready_q <= 1'b0;
                        if (n_in == 3'd0) begin
                            state_q  <= MUL_SEQ_DONE;
                            valid_q  <= 1'b1;
                            result_q <= '0;
                        end else begin
                            state_q <= MUL_SEQ_MUL;
                        end
                    end
                end
                MUL_SEQ_MUL: begin
                    if (kill_i) begin
                        state_q <= MUL_SEQ_IDLE;
                        ready_q <= 1'b1;
                    end else if (k_q == k_last_q) begin
                        state_q  <= MUL_SEQ_DONE;
                        valid_q  <= 1'b1;
                        ov_q     <= ov_d;
                        result_q <= res_d;
                    end
                end
                MUL_SEQ_DONE: begin
                    state_q <= MUL_SEQ_IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= MUL_SEQ_IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    // Operand latch, product counter and accumulator.
    always_ff @(posedge clk_i) begin
        if (ResetAll && rst_i) begin
            op_q     <= ZPN_SMBB16;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            acc_q    <= '0;
            k_q      <= '0;
            k_last_q <= '0;
        end else if (accept) begin
            op_q     <= op_in;
            a_q      <= op_a_i;
            b_q      <= op_b_i;
            c_q      <= op_c_i;
            acc_q    <= '0;
            k_q      <= '0;
            k_last_q <= 2'(n_in - 3'd1);
        end else if (state_q == MUL_SEQ_MUL) begin
            acc_q <= acc_d;
            k_q   <= k_q + 2'd1;
        end
    end

    // A flush arriving in DONE must still cancel the pulse it overlaps.
    assign ready_o  = ready_q;
    assign valid_o  = valid_q & ~kill_i;
    assign ov_set_o = ov_q & ~kill_i;
    assign result_o = result_q;

endmodule

// File: tb/tb_ibex_pext_mul_seq.sv
// Directed bench for ibex_pext_mul_seq with hand-computed expected results.
module tb_ibex_pext_mul_seq;
    import ibex_pkg_pext::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        en_i;
    logic [6:0]  operator_i;
    logic [31:0] op_a_i;
    logic [31:0] op_b_i;
    logic [31:0] op_c_i;
    logic        kill_i;
    logic        ready_o;
    logic        valid_o;
    logic [31:0] result_o;
    logic        ov_set_o;

    int n_chk  = 0;
    int n_pass = 0;

    ibex_pext_mul_seq dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .en_i       (en_i),
        .operator_i (operator_i),
        .op_a_i     (op_a_i),
        .op_b_i     (op_b_i),
        .op_c_i     (op_c_i),
        .kill_i     (kill_i),
        .ready_o    (ready_o),
        .valid_o    (valid_o),
        .result_o   (result_o),
        .ov_set_o   (ov_set_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Issue at a negedge while idle; accept edge ends cycle 0, result expected at cycle lat.
    task automatic run_op(input string tag, input logic [6:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] c, input int lat,
                          input logic [31:0] exp_res, input logic exp_ov);
        int   seen;
        logic rdy_hi;
        check({tag, " ready_before"}, 32'(ready_o), 32'd1);
        en_i       = 1'b1;
        operator_i = op;
        op_a_i     = a;
        op_b_i     = b;
        op_c_i     = c;
        @(posedge clk_i);
        #1;
        en_i   = 1'b0;
        seen   = 0;
        rdy_hi = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk_i);
            if (ready_o) rdy_hi = 1'b1;
            if (valid_o) begin
                seen = i;
                break;
            end
        end
        check({tag, " latency"}, 32'(seen), 32'(lat));
        check({tag, " busy_ready"}, 32'(rdy_hi), 32'd0);
        check({tag, " result"}, result_o, exp_res);
        check({tag, " ov"}, 32'(ov_set_o), 32'(exp_ov));
        @(negedge clk_i);
        check({tag, " valid_drop"}, 32'(valid_o), 32'd0);
        check({tag, " ready_after"}, 32'(ready_o), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_i      = 1'b1;
        en_i       = 1'b0;
        kill_i     = 1'b0;
        operator_i = '0;
        op_a_i     = '0;
        op_b_i     = '0;
        op_c_i     = '0;
        @(posedge clk_i);
        @(negedge clk_i);
        check("rst ready", 32'(ready_o), 32'd1);
        check("rst valid", 32'(valid_o), 32'd0);
        check("rst ov", 32'(ov_set_o), 32'd0);
        check("rst result", result_o, 32'd0);
        rst_i = 1'b0;
        @(negedge clk_i);

        run_op("smbb16", 7'(ZPN_SMBB16), 32'h0003_FFFE, 32'h7FFF_0005, 32'h0, 2, 32'hFFFF_FFF6, 1'b0);
        run_op("khmbb_min", 7'(ZPN_KHMBB), 32'h0000_8000, 32'h0000_8000, 32'h0, 2, 32'h0000_7FFF, 1'b1);
        run_op("khmbt", 7'(ZPN_KHMBT), 32'h0000_4000, 32'h4000_0000, 32'h0, 2, 32'h0000_2000, 1'b0);
        run_op("khmtt_neg", 7'(ZPN_KHMTT), 32'h8000_0000, 32'h4000_0000, 32'h0, 2, 32'hFFFF_C000, 1'b0);
        run_op("smtt16", 7'(ZPN_SMTT16), 32'h7FFF_0000, 32'h8000_0000, 32'h0, 2, 32'hC000_8000, 1'b0);
        run_op("kmda_sat", 7'(ZPN_KMDA), 32'h8000_8000, 32'h8000_8000, 32'h0, 3, 32'h7FFF_FFFF, 1'b1);
        run_op("kmxda", 7'(ZPN_KMXDA), 32'h0002_0003, 32'h0005_0007, 32'h0, 3, 32'd29, 1'b0);
        run_op("smds", 7'(ZPN_SMDS), 32'h0003_0002, 32'h0005_0004, 32'h0, 3, 32'd7, 1'b0);
        run_op("kmada", 7'(ZPN_KMADA), 32'h0002_0003, 32'h0004_0005, 32'hFFFF_FFF0, 3, 32'd7, 1'b0);
        run_op("smaqa", 7'(ZPN_SMAQA), 32'hFF02_0304, 32'h0102_0304, 32'd10, 5, 32'h0000_0026, 1'b0);
        run_op("umaqa", 7'(ZPN_UMAQA), 32'hFF02_0304, 32'h0102_0304, 32'd10, 5, 32'h0000_0126, 1'b0);
        run_op("kmabb_sat", 7'(ZPN_KMABB), 32'h0000_0010, 32'h0000_0001, 32'h7FFF_FFF0, 2, 32'h7FFF_FFFF, 1'b1);
        run_op("kmabt_negsat", 7'(ZPN_KMABT), 32'h0000_8000, 32'h7FFF_0000, 32'h8000_0000, 2, 32'h8000_0000, 1'b1);
        run_op("unsupported", 7'h7F, 32'h1234_5678, 32'h9ABC_DEF0, 32'h1, 1, 32'h0, 1'b0);

        // Flush SMAQA during product k=1, then a fresh SMBB16 straight after.
        en_i = 1'b1; operator_i = 7'(ZPN_SMAQA);
        op_a_i = 32'hFF02_0304; op_b_i = 32'h0102_0304; op_c_i = 32'd10;
        @(posedge clk_i); #1; en_i = 1'b0;
        @(negedge clk_i);
        check("kill_mul c1 valid", 32'(valid_o), 32'd0);
        @(posedge clk_i); #1; kill_i = 1'b1;
        @(negedge clk_i);
        check("kill_mul c2 valid", 32'(valid_o), 32'd0);
        @(posedge clk_i); #1; kill_i = 1'b0;
        @(negedge clk_i);
        check("kill_mul c3 ready", 32'(ready_o), 32'd1);
        check("kill_mul c3 valid", 32'(valid_o), 32'd0);
        run_op("after_kill_smbb16", 7'(ZPN_SMBB16), 32'h0003_FFFE, 32'h7FFF_0005, 32'h0, 2, 32'hFFFF_FFF6, 1'b0);

        // Flush landing on the DONE cycle hides the pulse and the flag.
        en_i = 1'b1; operator_i = 7'(ZPN_KMDA);
        op_a_i = 32'h8000_8000; op_b_i = 32'h8000_8000; op_c_i = 32'h0;
        @(posedge clk_i); #1; en_i = 1'b0;
        @(posedge clk_i);
        @(posedge clk_i); #1; kill_i = 1'b1;
        @(negedge clk_i);
        check("kill_done valid", 32'(valid_o), 32'd0);
        check("kill_done ov", 32'(ov_set_o), 32'd0);
        @(posedge clk_i); #1; kill_i = 1'b0;
        @(negedge clk_i);
        check("kill_done ready", 32'(ready_o), 32'd1);

        // Kill while idle blocks the accept.
        kill_i = 1'b1; en_i = 1'b1; operator_i = 7'(ZPN_SMBB16);
        @(posedge clk_i); #1; kill_i = 1'b0; en_i = 1'b0;
        @(negedge clk_i);
        check("kill_idle ready", 32'(ready_o), 32'd1);
        @(negedge clk_i);
        check("kill_idle valid", 32'(valid_o), 32'd0);

        // Reset during the MUL phase of KMADA.
        en_i = 1'b1; operator_i = 7'(ZPN_KMADA);
        op_a_i = 32'h0002_0003; op_b_i = 32'h0004_0005; op_c_i = 32'hFFFF_FFF0;
        @(posedge clk_i); #1; en_i = 1'b0; rst_i = 1'b1;
        @(posedge clk_i); #1; rst_i = 1'b0;
        @(negedge clk_i);
        check("rst_mul ready", 32'(ready_o), 32'd1);
        check("rst_mul valid", 32'(valid_o), 32'd0);
        @(negedge clk_i);
        check("rst_mul valid2", 32'(valid_o), 32'd0);
        run_op("after_rst_kmada", 7'(ZPN_KMADA), 32'h0002_0003, 32'h0004_0005, 32'hFFFF_FFF0, 3, 32'd7, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
